// File: rtl/seq_comp_pkg.sv
// Shared FSM state and {lt,eq,gt} result encoding for the sequential magnitude comparator.
package seq_comp_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Result vector ordered {lt, eq, gt}; always one-hot.
   typedef logic [2:0] res_t;

   localparam res_t RES_LT = 3'b100;
   localparam res_t RES_EQ = 3'b010;
   localparam res_t RES_GT = 3'b001;

   // Result taken from a less-significant stage when every local chunk matched.
   function automatic res_t cascade_res(input logic lt_in, input logic eq_in, input logic gt_in);
      if (gt_in)
         return RES_GT;
      else if (lt_in)
         return RES_LT;
      else if (eq_in)
         return RES_EQ;
      return RES_EQ;
   endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit magnitude compare; inv_msb flips both top bits so a
// two's-complement sign chunk orders correctly with an unsigned compare.
module chunk_cmp #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             inv_msb,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   logic [CHUNK-1:0] flip;
   logic [CHUNK-1:0] a_m;
   logic [CHUNK-1:0] b_m;

   assign flip = CHUNK'(inv_msb) << (CHUNK - 1);
   assign a_m  = a ^ flip;
   assign b_m  = b ^ flip;

   assign lt = (a_m <  b_m);
   assign eq = (a_m == b_m);
   assign gt = (a_m >  b_m);

endmodule

// File: rtl/seq_mag_comp.sv
// Sequential A/B magnitude comparator, one CHUNK per cycle MSB-first with early exit;
// done pulses n+1 cycles after start (n chunks examined); start is ignored while busy.
module seq_mag_comp
   import seq_comp_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int CHUNK  = 8,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int CW     = $clog2(NCHUNK + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   input  logic             lt_in,
   input  logic             eq_in,
   input  logic             gt_in,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [CW-1:0]    chunks_used
);

   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             mode_q;
   logic             lt_in_q;
   logic             eq_in_q;
   logic             gt_in_q;
   res_t             res;

   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic             top_chunk;
   logic             last_chunk;
   logic             c_lt;
   logic             c_eq;
   logic             c_gt;
   logic             accept;

   assign a_sl       = a_q[idx*CHUNK +: CHUNK];
   assign b_sl       = b_q[idx*CHUNK +: CHUNK];
   assign top_chunk  = (idx == IW'(NCHUNK - 1));
   assign last_chunk = (idx == '0);
   assign accept     = start && (state != S_CMP);

   chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
      .a       (a_sl),
      .b       (b_sl),
      .inv_msb (mode_q & top_chunk),
      .lt      (c_lt),
      .eq      (c_eq),
      .gt      (c_gt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CMP;
         S_CMP:   if (!c_eq || last_chunk) state_nxt = S_DONE;
         S_DONE:  state_nxt = start ? S_CMP : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx         <= '0;
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= 1'b0;
         lt_in_q     <= 1'b0;
         eq_in_q     <= 1'b0;
         gt_in_q     <= 1'b0;
         res         <= RES_EQ;
         chunks_used <= '0;
      end else if (accept) begin
         idx     <= IW'(NCHUNK - 1);
         cnt     <= '0;
         a_q     <= a;
         b_q     <= b;
         mode_q  <= signed_mode;
         lt_in_q <= lt_in;
         eq_in_q <= eq_in;
         gt_in_q <= gt_in;
      end else if (state == S_CMP) begin
         cnt <= cnt + 1'b1;
         if (!c_eq) begin
            res         <= c_lt ? RES_LT : (c_gt ? RES_GT : RES_EQ);
            chunks_used <= cnt + 1'b1;
         end else if (last_chunk) begin
            res         <= cascade_res(lt_in_q, eq_in_q, gt_in_q);
            chunks_used <= cnt + 1'b1;
         end else begin
            idx <= idx - 1'b1;
         end
      end
   end

   assign busy         = (state == S_CMP);
   assign done         = (state == S_DONE);
   assign {lt, eq, gt} = res;

endmodule

// File: doc/seq_mag_comp.md
SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK (NCHUNK = WIDTH/CHUNK).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a comparison.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-009 SHALL have ports lt_in, eq_in, gt_in  input  1 each  cascade result from a less-significant stage.
REQ-010 SHALL have port busy  output  1  comparison in progress.
REQ-011 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have ports lt, eq, gt  output  1 each  A<B, A==B, A>B; exactly one high after the first done.
REQ-013 SHALL have port chunks_used  output  clog2(NCHUNK+1)  chunks examined for the last result.

Function
REQ-014 SHALL implement FSM states IDLE, CMP, DONE.
REQ-015 In IDLE or DONE, start high SHALL latch a, b, signed_mode, lt_in/eq_in/gt_in, set chunk index to NCHUNK-1, clear the chunk counter, and move to CMP.
REQ-016 In CMP, start SHALL be ignored and latched operands SHALL NOT change.
REQ-017 Each CMP cycle SHALL compare one CHUNK-bit slice, most significant first, and increment the chunk counter.
REQ-018 In signed mode, the most significant chunk SHALL be compared with its top bit inverted; all other chunks SHALL compare unsigned.
REQ-019 If the slice differs, the result SHALL be set from that slice and the FSM SHALL go to DONE (early termination).
REQ-020 If the slice is equal and the index is 0, the result SHALL come from the latched cascade inputs and the FSM SHALL go to DONE; otherwise the index SHALL decrement and the FSM SHALL stay in CMP.
REQ-021 Cascade priority SHALL be gt_in > lt_in > eq_in; none set SHALL yield eq.
REQ-022 With start sampled in cycle 0 and n chunks examined (1..NCHUNK), done SHALL be high in cycle n+1 only.
REQ-023 busy SHALL be high exactly while in CMP.
REQ-024 lt/eq/gt and chunks_used SHALL update on the edge entering DONE and hold until the next result.
REQ-025 DONE SHALL last one cycle, then go to IDLE, unless start is high, which begins a new comparison back-to-back.

Reset
REQ-026 rst_n low at a rising edge SHALL force IDLE, busy=0, done=0, lt=0, eq=1, gt=0, chunks_used=0.
REQ-027 Reset during CMP SHALL abort the comparison with no done pulse.
REQ-028 rst_n low SHALL take priority over start.

Structure
REQ-029 The state enum and the {lt,eq,gt} result encoding SHALL live in shared package seq_comp_pkg.
REQ-030 Per-chunk comparison SHALL be a combinational sub-module chunk_cmp (CHUNK-bit, with an invert-MSB input) instantiated once.
REQ-031 Registers SHALL be limited to state, index, counter, latched operands/mode/cascade, and outputs.

Verification
REQ-032 WIDTH=32, CHUNK=8, unsigned, a=0x0000004F, b=0x00000078 -> done 5 cycles after start, lt=1, chunks_used=4.
REQ-033 Unsigned, a=0xCF000000, b=0x78000000 -> done 2 cycles after start, gt=1, chunks_used=1; same operands signed -> lt=1.
REQ-034 a=b=0x000000CF, cascade gt_in=1 -> gt=1, chunks_used=4; cascade all 0 -> eq=1.
REQ-035 start pulsed during CMP with new operands -> ignored; result matches the first operands; start held in DONE -> back-to-back result with no idle cycle.
REQ-036 rst_n low for one cycle mid-CMP -> no done, outputs at reset values, next start yields a correct result.
